// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin, burst-bounded sharing of the fifo_dual write port
// Each word carries {source ID, payload} so the read side can demultiplex.
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 16,
  parameter int MAX_BURST = 8,
  parameter int CNT_W     = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      en_i,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ*DATA_W-1:0] src_data_i,
  output logic [NUM_REQ-1:0]        ack_o,
  output logic [NUM_REQ-1:0]        grant_o,
  input  logic                      full_i,
  output logic                      wr_en_o,
  output logic [DATA_W+1:0]         din_o,
  output logic                      busy_o,
  output logic [NUM_REQ*CNT_W-1:0]  word_cnt_o
);
  typedef enum logic {IDLE, GRANT} state_e;
  state_e                     state_q, state_d;
  logic [NUM_REQ-1:0]         grant_q, grant_d;
  logic [1:0]                 rr_q, rr_d;
  logic [7:0]                 burst_q, burst_d;
  logic [NUM_REQ*CNT_W-1:0]   word_cnt_q, word_cnt_d;
  logic [1:0]                 owner, sel;
  logic                       own_req, last;
  always_comb begin
    owner = '0;
    for (int i = 0; i < NUM_REQ; i++) if (grant_q[i]) owner = 2'(i);
    // scan downwards so the candidate closest to rr_q wins
    sel = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) if (req_i[(int'(rr_q) + k) % NUM_REQ]) sel = 2'((int'(rr_q) + k) % NUM_REQ);
  end
  assign ack_o   = (state_q == GRANT && !full_i) ? (grant_q & req_i) : '0;
  assign wr_en_o = |ack_o;
  assign din_o   = (grant_q == '0) ? '0 : {owner, src_data_i[owner*DATA_W +: DATA_W]};
  assign own_req = |(grant_q & req_i);
  assign last    = wr_en_o && burst_q == 8'(MAX_BURST - 1);
  assign busy_o  = state_q == GRANT;
  assign grant_o = grant_q;
  assign word_cnt_o = word_cnt_q;
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    burst_d = burst_q;
    if (state_q == IDLE) begin
      if (en_i && |req_i) begin
        state_d = GRANT;
        grant_d = NUM_REQ'(1) << sel;
        burst_d = '0;
      end
    end else if (!own_req || last) begin
      state_d = IDLE;
      grant_d = '0;
      rr_d    = (owner == 2'(NUM_REQ - 1)) ? 2'd0 : owner + 2'd1;
    end else if (wr_en_o) begin
      burst_d = burst_q + 8'd1;
    end
  end
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
    assign word_cnt_d[g*CNT_W +: CNT_W] = (ack_o[g] && !(&word_cnt_q[g*CNT_W +: CNT_W]))
      ? word_cnt_q[g*CNT_W +: CNT_W] + 1'b1 : word_cnt_q[g*CNT_W +: CNT_W];
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      rr_q       <= '0;
      burst_q    <= '0;
      word_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_q       <= rr_d;
      burst_q    <= burst_d;
      word_cnt_q <= word_cnt_d;
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed steps for reset, bursts, round-robin, stalls, early release, en and reset mid-burst
module tb_fifo_wr_arbiter;
  logic        clk = 1'b0;
  logic        rst_n, en, full, wr_en, busy;
  logic [3:0]  req, ack, grant;
  logic [63:0] data;
  logic [17:0] din;
  logic [63:0] word_cnt;
  int          n_assert = 0;
  int          n_fail = 0;

  fifo_wr_arbiter dut (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .req_i(req), .src_data_i(data),
    .ack_o(ack), .grant_o(grant), .full_i(full), .wr_en_o(wr_en), .din_o(din),
    .busy_o(busy), .word_cnt_o(word_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; full = 1'b0; req = 4'b1111;
    data = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    repeat (3) cyc;
    chk("rst_grant", grant, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_ack", ack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_word_cnt", word_cnt, 0);
    rst_n = 1'b1; #1;
    chk("release_no_grant", grant, 0);
    cyc;
    chk("first_grant", grant, 4'b0001);
    chk("first_busy", busy, 1);
    req = 4'b0000; #1;
    chk("drop_ack", ack, 0);
    cyc;
    chk("drop_idle", grant, 0);
    // single source, two bursts of 8
    req = 4'b0100;
    for (int r = 0; r < 2; r++) begin
      cyc;
      chk("single_grant", grant, 4'b0100);
      for (int w = 0; w < 8; w++) begin
        chk("single_wr_en", wr_en, 1);
        chk("single_din", din, 18'h23333);
        cyc;
      end
      chk("single_gap_wr_en", wr_en, 0);
      chk("single_gap_grant", grant, 0);
    end
    req = 4'b0000;
    chk("single_cnt2", word_cnt[32 +: 16], 16);
    // round-robin from a fresh reset
    rst_n = 1'b0; #1;
    cyc;
    rst_n = 1'b1; req = 4'b1111; #1;
    for (int b = 0; b < 5; b++) begin
      logic [1:0] ob;
      ob = 2'(b % 4);
      cyc;
      chk("rr_grant", grant, 4'b0001 << ob);
      for (int w = 0; w < 8; w++) begin
        chk("rr_wr_en", wr_en, 1);
        chk("rr_din", din, {ob, data[ob*16 +: 16]});
        cyc;
      end
      chk("rr_gap", grant, 0);
    end
    chk("rr_cnt", word_cnt, 64'h0008_0008_0008_0010);
    // full stall mid-burst on source 1
    cyc;
    chk("stall_grant", grant, 4'b0010);
    for (int w = 0; w < 3; w++) begin chk("stall_pre_wr", wr_en, 1); cyc; end
    full = 1'b1; #1;
    for (int w = 0; w < 5; w++) begin
      chk("stall_wr_en", wr_en, 0);
      chk("stall_grant_hold", grant, 4'b0010);
      cyc;
    end
    full = 1'b0; #1;
    for (int w = 0; w < 5; w++) begin chk("stall_post_wr", wr_en, 1); cyc; end
    chk("stall_end", grant, 0);
    chk("stall_cnt1", word_cnt[16 +: 16], 16);
    // early release of source 1, source 3 next
    req = 4'b0010;
    cyc;
    chk("early_grant", grant, 4'b0010);
    for (int w = 0; w < 2; w++) begin chk("early_wr", wr_en, 1); cyc; end
    req = 4'b1001; #1;
    chk("early_drop_wr", wr_en, 0);
    cyc;
    chk("early_idle", grant, 0);
    cyc;
    chk("early_next_src3", grant, 4'b1000);
    req = 4'b0000; #1;
    chk("early_src3_ack", ack, 0);
    cyc;
    chk("early_src3_exit", grant, 0);
    chk("early_cnt1", word_cnt[16 +: 16], 18);
    // en=0 mid-burst
    req = 4'b0001;
    cyc;
    chk("en_grant", grant, 4'b0001);
    for (int w = 0; w < 2; w++) begin chk("en_pre_wr", wr_en, 1); cyc; end
    en = 1'b0;
    for (int w = 0; w < 6; w++) begin chk("en_post_wr", wr_en, 1); cyc; end
    chk("en_end", grant, 0);
    for (int w = 0; w < 3; w++) begin
      cyc;
      chk("en_no_grant", grant, 0);
      chk("en_no_busy", busy, 0);
    end
    chk("en_cnt0", word_cnt[0 +: 16], 24);
    // reset at word 4 of a burst
    en = 1'b1;
    cyc;
    chk("mid_grant", grant, 4'b0001);
    for (int w = 0; w < 3; w++) begin chk("mid_wr", wr_en, 1); cyc; end
    chk("mid_word4_wr", wr_en, 1);
    rst_n = 1'b0; #1;
    chk("mid_rst_wr_en", wr_en, 0);
    chk("mid_rst_grant", grant, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_cnt", word_cnt, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
